// File: rtl/vmx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vmx_pkg
//  Purpose  : State encoding and phase-length helpers shared by the tile
//             scheduler and its address generator.
//  Revision : 1.0 - initial release
// ============================================================================
package vmx_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GETW = 3'd1,
        S_LOAD = 3'd2,
        S_COMP = 3'd3,
        S_EXPO = 3'd4,
        S_DONE = 3'd5
    } state_t;

    function automatic int getw_len(input int pe);
        return pe;
    endfunction

    function automatic int load_len(input int pe);
        return pe;
    endfunction

    // Drain time for the last activation to ripple through a skewed array.
    function automatic int comp_len(input int pe);
        return 2 * pe - 1;
    endfunction

    function automatic int expo_len(input int pe);
        return pe;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmx_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vmx_addr_gen
//  Purpose  : Tile row address: base + tile*PE_SIZE + cnt, wrapping at ADDR_W.
//  Revision : 1.0 - initial release
// ============================================================================
module vmx_addr_gen
    import vmx_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TILE_W  = 8,
    parameter int CNT_W   = 3,
    parameter int PE_SIZE = 4
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [TILE_W-1:0] tile,
    input  logic [CNT_W-1:0]  cnt,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] w_tile_off;

    assign w_tile_off = ADDR_W'(tile) * ADDR_W'(PE_SIZE);
    assign addr       = base + w_tile_off + ADDR_W'(cnt);

endmodule
`default_nettype wire

// File: rtl/vmx_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vmx_tile_scheduler
//  Purpose  : Per-tile GETW/LOAD/COMP/EXPO sequencer for the systolic array.
//             Optional perf counters (cyc_cnt, tile_cnt) under VMX_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module vmx_tile_scheduler
    import vmx_pkg::*;
#(
    parameter int PE_SIZE = 4,
    parameter int ADDR_W  = 12,
    parameter int TILE_W  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] n_tiles,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] o_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              load_weight,
    output logic              act_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
`ifdef VMX_PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [TILE_W-1:0] tile_cnt
`endif
);

    localparam int CNT_W = (2 * PE_SIZE > 2) ? $clog2(2 * PE_SIZE) : 1;
    localparam logic [CNT_W-1:0] C_GETW_LAST = CNT_W'(getw_len(PE_SIZE) - 1);
    localparam logic [CNT_W-1:0] C_LOAD_LAST = CNT_W'(load_len(PE_SIZE) - 1);
    localparam logic [CNT_W-1:0] C_COMP_LAST = CNT_W'(comp_len(PE_SIZE) - 1);
    localparam logic [CNT_W-1:0] C_EXPO_LAST = CNT_W'(expo_len(PE_SIZE) - 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [TILE_W-1:0] r_tile, w_tile_nxt;
    logic [TILE_W:0]   w_tile_inc;
    logic              w_last_tile;
    logic              w_start_ok;
    logic [TILE_W-1:0] r_n_tiles;
    logic [ADDR_W-1:0] r_w_base, r_a_base, r_o_base;
    logic [ADDR_W-1:0] w_rd_base, w_rd_sum, w_wr_sum;

    assign w_start_ok  = start & ~abort & (r_state == S_IDLE);
    assign w_tile_inc  = {1'b0, r_tile} + (TILE_W + 1)'(1);
    assign w_last_tile = (w_tile_inc >= {1'b0, r_n_tiles});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tile  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tile  <= w_tile_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tile_nxt  = r_tile;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_cnt_nxt   = '0;
                    w_tile_nxt  = '0;
                    w_state_nxt = (n_tiles == '0) ? S_DONE : S_GETW;
                end
            end
            S_GETW: begin
                if (r_cnt == C_GETW_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_LOAD: begin
                if (r_cnt == C_LOAD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_COMP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_COMP: begin
                if (r_cnt == C_COMP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_EXPO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_EXPO: begin
                if (r_cnt == C_EXPO_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_last_tile) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_tile_nxt  = w_tile_inc[TILE_W-1:0];
                        w_state_nxt = S_GETW;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_tile_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_n_tiles <= '0;
            r_w_base  <= '0;
            r_a_base  <= '0;
            r_o_base  <= '0;
        end else if (w_start_ok) begin
            r_n_tiles <= n_tiles;
            r_w_base  <= w_base;
            r_a_base  <= a_base;
            r_o_base  <= o_base;
        end
    end

    // Strobes trail rd_en by one cycle to line up with BRAM read data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_weight <= 1'b0;
            act_valid   <= 1'b0;
        end else begin
            load_weight <= ~abort & (r_state == S_GETW);
            act_valid   <= ~abort & (r_state == S_LOAD);
        end
    end

    assign w_rd_base = (r_state == S_LOAD) ? r_a_base : r_w_base;

    vmx_addr_gen #(
        .ADDR_W  (ADDR_W),
        .TILE_W  (TILE_W),
        .CNT_W   (CNT_W),
        .PE_SIZE (PE_SIZE)
    ) u_rd_addr (
        .base (w_rd_base),
        .tile (r_tile),
        .cnt  (r_cnt),
        .addr (w_rd_sum)
    );

    vmx_addr_gen #(
        .ADDR_W  (ADDR_W),
        .TILE_W  (TILE_W),
        .CNT_W   (CNT_W),
        .PE_SIZE (PE_SIZE)
    ) u_wr_addr (
        .base (r_o_base),
        .tile (r_tile),
        .cnt  (r_cnt),
        .addr (w_wr_sum)
    );

    assign rd_en   = (r_state == S_GETW) || (r_state == S_LOAD);
    assign wr_en   = (r_state == S_EXPO);
    assign rd_addr = rd_en ? w_rd_sum : '0;
    assign wr_addr = wr_en ? w_wr_sum : '0;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign state   = r_state;

`ifdef VMX_PERF_CNT_EN
    // The accepting start cycle is part of the job, so the count restarts at 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cyc_cnt  <= '0;
            tile_cnt <= '0;
        end else if (w_start_ok) begin
            cyc_cnt  <= 32'd1;
            tile_cnt <= '0;
        end else begin
            if (busy && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if ((r_state == S_EXPO) && (r_cnt == C_EXPO_LAST) && !abort) begin
                tile_cnt <= tile_cnt + TILE_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire
